rem_tx_mapper: RTL and testbench

Transmit-side PUSCH resource element mapper, the counterpart of the receive-side mapper/ping-pong path. For each OFDM symbol from `Sym_Start` to `Sym_End` it emits a full `FFT_SIZE`-sample frequency-domain stream toward the IFFT:
- allocated subcarriers are filled from the modulated-data stream, or from the DMRS stream on the DMRS symbol;
- every other bin is zero.

It pulls its sources with valid/ready handshakes and honours IFFT backpressure.

---
 rtl/rem_tx_pkg.sv | 16 +
 rtl/rem_tx_out_stage.sv | 47 ++++
 rtl/rem_tx_mapper.sv | 130 +++++++++++++
 tb/tb_rem_tx_mapper.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rem_tx_pkg.sv
// rem_tx_pkg: shared state type, widths and allocation-bound clipping for rem_tx_mapper
package rem_tx_pkg;
  localparam int FFT_SIZE = 2048;
  localparam int ADDR_W = 11;
  localparam int BOUND_W = 12;
  localparam int SYM_W = 4;
  localparam int RB_W = 7;
  localparam int SC_PER_RB = 12;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  // Upper allocation bound, exclusive; saturates at FFT_SIZE so the mapping never wraps to bin 0.
  function automatic logic [BOUND_W-1:0] clip_hi(input logic [ADDR_W-1:0] n_sc, input logic [RB_W-1:0] n_rb);
    logic [BOUND_W-1:0] s;
    s = BOUND_W'(n_sc) + BOUND_W'(n_rb) * BOUND_W'(SC_PER_RB);
    return (s > BOUND_W'(FFT_SIZE)) ? BOUND_W'(FFT_SIZE) : s;
  endfunction
endpackage

// File: rtl/rem_tx_out_stage.sv
// rem_tx_out_stage: output register with valid/ready hold and addr/last sideband
module rem_tx_out_stage
  import rem_tx_pkg::*;
#(
  parameter int W = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                ready_i,
  input  logic                last_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic signed [W-1:0] i_i,
  input  logic signed [W-1:0] q_i,
  output logic                valid_o,
  output logic                last_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic signed [W-1:0] i_o,
  output logic signed [W-1:0] q_o
);
  logic valid_q, valid_d, last_q;
  logic [ADDR_W-1:0] addr_q;
  logic signed [W-1:0] i_q, q_q;
  assign valid_d = load_i | (valid_q & ~ready_i);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      i_q     <= '0;
      q_q     <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        last_q <= last_i;
        addr_q <= addr_i;
        i_q    <= i_i;
        q_q    <= q_i;
      end
    end
  end
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign addr_o  = addr_q;
  assign i_o     = i_q;
  assign q_o     = q_q;
endmodule

// File: rtl/rem_tx_mapper.sv
// rem_tx_mapper: PUSCH transmit RE mapper producing FFT_SIZE-bin symbols for the IFFT.
// Define REM_TX_DMRS_BOOST_EN to apply a +6 dB (x2) boost to DMRS samples.
module rem_tx_mapper
  import rem_tx_pkg::*;
#(
  parameter int FFT_Len  = 18,
  parameter int DMRS_Len = 9
) (
  input  logic                       CLK_RE,
  input  logic                       RST_RE,
  input  logic                       Start,
  input  logic [ADDR_W-1:0]          N_sc,
  input  logic [RB_W-1:0]            N_rb,
  input  logic [SYM_W-1:0]           Sym_Start,
  input  logic [SYM_W-1:0]           Sym_End,
  input  logic [SYM_W-1:0]           Dmrs_Sym,
  input  logic signed [FFT_Len-1:0]  Data_I,
  input  logic signed [FFT_Len-1:0]  Data_Q,
  input  logic                       Data_Valid_In,
  output logic                       Data_Ready,
  input  logic signed [DMRS_Len-1:0] Dmrs_I,
  input  logic signed [DMRS_Len-1:0] Dmrs_Q,
  input  logic                       Dmrs_Valid_In,
  output logic                       Dmrs_Ready,
  output logic signed [FFT_Len-1:0]  IFFT_I,
  output logic signed [FFT_Len-1:0]  IFFT_Q,
  output logic                       IFFT_Valid,
  input  logic                       IFFT_Ready,
  output logic [ADDR_W-1:0]          IFFT_addr,
  output logic                       IFFT_Last,
  output logic                       Slot_Done,
  output logic                       Busy
);
  state_e state_q, state_d;
  logic [SYM_W-1:0] sym_q, sym_d, end_q, end_d, dsym_q, dsym_d;
  logic [ADDR_W-1:0] k_q, k_d, lo_q, lo_d;
  logic [BOUND_W-1:0] hi_q, hi_d;
  logic done_q, done_d;
  logic run, alloc, is_dmrs, src_ok, load, last_bin;
  logic signed [FFT_Len-1:0] dmrs_i_ext, dmrs_q_ext, smp_i, smp_q;
`ifdef REM_TX_DMRS_BOOST_EN
  assign dmrs_i_ext = {{(FFT_Len-DMRS_Len-1){Dmrs_I[DMRS_Len-1]}}, Dmrs_I, 1'b0};
  assign dmrs_q_ext = {{(FFT_Len-DMRS_Len-1){Dmrs_Q[DMRS_Len-1]}}, Dmrs_Q, 1'b0};
`else
  assign dmrs_i_ext = {{(FFT_Len-DMRS_Len){Dmrs_I[DMRS_Len-1]}}, Dmrs_I};
  assign dmrs_q_ext = {{(FFT_Len-DMRS_Len){Dmrs_Q[DMRS_Len-1]}}, Dmrs_Q};
`endif
  assign run        = state_q == RUN;
  assign alloc      = (k_q >= lo_q) && ({1'b0, k_q} < hi_q);
  assign is_dmrs    = sym_q == dsym_q;
  assign src_ok     = !alloc || (is_dmrs ? Dmrs_Valid_In : Data_Valid_In);
  assign load       = run && (!IFFT_Valid || IFFT_Ready) && src_ok;
  assign last_bin   = k_q == ADDR_W'(FFT_SIZE - 1);
  assign Data_Ready = load && alloc && !is_dmrs;
  assign Dmrs_Ready = load && alloc && is_dmrs;
  assign smp_i      = !alloc ? '0 : is_dmrs ? dmrs_i_ext : Data_I;
  assign smp_q      = !alloc ? '0 : is_dmrs ? dmrs_q_ext : Data_Q;
  assign Slot_Done  = done_q;
  assign Busy       = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    end_d   = end_q;
    dsym_d  = dsym_q;
    k_d     = k_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (Start) begin
        lo_d   = N_sc;
        hi_d   = clip_hi(N_sc, N_rb);
        end_d  = Sym_End;
        dsym_d = Dmrs_Sym;
        sym_d  = Sym_Start;
        k_d    = '0;
        done_d = Sym_Start > Sym_End;
        state_d = (Sym_Start > Sym_End) ? IDLE : RUN;
      end
      RUN: if (load) begin
        k_d = k_q + ADDR_W'(1);
        if (last_bin) begin
          state_d = (sym_q == end_q) ? DRAIN : RUN;
          sym_d   = (sym_q == end_q) ? sym_q : sym_q + SYM_W'(1);
        end
      end
      DRAIN: if (IFFT_Valid && IFFT_Ready) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK_RE or negedge RST_RE) begin
    if (!RST_RE) begin
      state_q <= IDLE;
      sym_q   <= '0;
      end_q   <= '0;
      dsym_q  <= '0;
      k_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      end_q   <= end_d;
      dsym_q  <= dsym_d;
      k_q     <= k_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
    end
  end
  rem_tx_out_stage #(.W(FFT_Len)) u_out (
    .clk     (CLK_RE),
    .rst_n   (RST_RE),
    .load_i  (load),
    .ready_i (IFFT_Ready),
    .last_i  (last_bin),
    .addr_i  (k_q),
    .i_i     (smp_i),
    .q_i     (smp_q),
    .valid_o (IFFT_Valid),
    .last_o  (IFFT_Last),
    .addr_o  (IFFT_addr),
    .i_o     (IFFT_I),
    .q_o     (IFFT_Q)
  );
endmodule

// File: tb/tb_rem_tx_mapper.sv
// tb_rem_tx_mapper: scoreboard bench for rem_tx_mapper
module tb_rem_tx_mapper;
`ifdef REM_TX_DMRS_BOOST_EN
  localparam int DMUL = 2;
`else
  localparam int DMUL = 1;
`endif
  localparam int DMRS_IV = -256;
  localparam int DMRS_QV = 100;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [10:0] n_sc = '0;
  logic [6:0] n_rb = '0;
  logic [3:0] sym_start = '0, sym_end = '0, dmrs_sym = '0;
  logic signed [17:0] data_i, data_q;
  logic data_valid = 1'b1, data_ready;
  logic signed [8:0] dmrs_i, dmrs_q;
  logic dmrs_valid = 1'b1, dmrs_ready;
  logic signed [17:0] ifft_i, ifft_q;
  logic ifft_valid, ifft_last, slot_done, busy;
  logic ifft_ready = 1'b1;
  logic [10:0] ifft_addr;
  int n_tests = 0, n_fail = 0;
  int cyc = 0, data_n = 0, dmrs_n = 0;
  int done_cyc = 0, hs_cyc = 0, hs_addr = -1, first_v = -1, valid_cnt = 0, start_cyc = 0;
  logic done_seen = 1'b0, sb_on = 1'b0, rnd = 1'b0, bp = 1'b0, prev_stall = 1'b0;
  logic [63:0] prev_word = '0;
  logic [47:0] exp_q[$];
  rem_tx_mapper dut (
    .CLK_RE(clk), .RST_RE(rst_n), .Start(start), .N_sc(n_sc), .N_rb(n_rb),
    .Sym_Start(sym_start), .Sym_End(sym_end), .Dmrs_Sym(dmrs_sym),
    .Data_I(data_i), .Data_Q(data_q), .Data_Valid_In(data_valid), .Data_Ready(data_ready),
    .Dmrs_I(dmrs_i), .Dmrs_Q(dmrs_q), .Dmrs_Valid_In(dmrs_valid), .Dmrs_Ready(dmrs_ready),
    .IFFT_I(ifft_i), .IFFT_Q(ifft_q), .IFFT_Valid(ifft_valid), .IFFT_Ready(ifft_ready),
    .IFFT_addr(ifft_addr), .IFFT_Last(ifft_last), .Slot_Done(slot_done), .Busy(busy)
  );
  always #5 clk = ~clk;
  assign data_i = 18'(data_n * 3 + 1);
  assign data_q = 18'(-data_n);
  assign dmrs_i = 9'(DMRS_IV);
  assign dmrs_q = 9'(DMRS_QV);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (data_valid && data_ready) data_n <= data_n + 1;
    if (dmrs_valid && dmrs_ready) dmrs_n <= dmrs_n + 1;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    data_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    dmrs_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    ifft_ready = bp ? (((cyc / 3) % 2) == 0) : 1'b1;
  end
  always @(negedge clk) begin
    logic [63:0] word;
    word = {15'd0, ifft_valid, ifft_addr, ifft_last, ifft_i, ifft_q};
    if (slot_done) begin
      done_seen = 1'b1;
      done_cyc = cyc;
    end
    if (ifft_valid) begin
      valid_cnt++;
      if (first_v < 0) first_v = cyc;
    end
    if (prev_stall) chk("hold", word, prev_word);
    prev_stall = ifft_valid && !ifft_ready;
    prev_word = word;
    if (prev_stall) chk("rdy_bp", {data_ready, dmrs_ready}, 2'b00);
    if (ifft_valid && ifft_ready) begin
      hs_cyc = cyc;
      hs_addr = int'(ifft_addr);
      if (sb_on) begin
        if (exp_q.size() == 0) chk("extra", 1, 0);
        else chk("out", word[47:0], exp_q.pop_front());
      end
    end
  end
  task automatic run_slot(input int nsc, input int nrb, input int s0, input int s1, input int ds);
    int hi, e, d0, m0, nalloc, nsym, guard;
    logic [17:0] ei, eq;
    hi = nsc + 12 * nrb;
    if (hi > 2048) hi = 2048;
    nalloc = (hi > nsc) ? hi - nsc : 0;
    nsym = (s1 >= s0) ? s1 - s0 + 1 : 0;
    e = data_n;
    d0 = data_n;
    m0 = dmrs_n;
    exp_q.delete();
    for (int s = s0; s <= s1; s++)
      for (int k = 0; k < 2048; k++) begin
        if (k >= nsc && k < hi) begin
          if (s == ds) begin
            ei = 18'(DMRS_IV * DMUL);
            eq = 18'(DMRS_QV * DMUL);
          end else begin
            ei = 18'(e * 3 + 1);
            eq = 18'(-e);
            e++;
          end
        end else begin
          ei = '0;
          eq = '0;
        end
        exp_q.push_back({11'(k), k == 2047, ei, eq});
      end
    n_sc = 11'(nsc);
    n_rb = 7'(nrb);
    sym_start = 4'(s0);
    sym_end = 4'(s1);
    dmrs_sym = 4'(ds);
    done_seen = 1'b0;
    first_v = -1;
    valid_cnt = 0;
    sb_on = 1'b1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while (!done_seen && guard < 30000) begin
      @(posedge clk);
      guard++;
    end
    chk("timeout", done_seen, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("q_empty", exp_q.size(), 0);
    chk("data_used", data_n - d0, e - d0);
    chk("dmrs_used", dmrs_n - m0, (ds >= s0 && ds <= s1) ? nalloc : 0);
    chk("busy_end", busy, 1'b0);
    if (nsym == 0) begin
      chk("done_t0", done_cyc, start_cyc + 1);
      chk("no_valid", valid_cnt, 0);
    end else begin
      chk("done_hs", done_cyc, hs_cyc + 1);
      if (!rnd && !bp) begin
        chk("done_lat", done_cyc, start_cyc + 2 + nsym * 2048);
        chk("first_v", first_v, start_cyc + 2);
      end
    end
  endtask
  initial begin
    int d0, guard;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {ifft_valid, ifft_last, slot_done, busy, data_ready, dmrs_ready}, 6'd0);
    chk("rst_addr", ifft_addr, 11'd0);
    chk("rst_iq", {ifft_i, ifft_q}, 36'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle", {busy, ifft_valid}, 2'b00);
    run_slot(100, 2, 0, 1, 5);
    run_slot(100, 2, 2, 2, 2);
    run_slot(2040, 1, 0, 0, 7);
    rnd = 1'b1;
    bp = 1'b1;
    run_slot(100, 2, 0, 1, 5);
    rnd = 1'b0;
    bp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_slot(300, 0, 0, 0, 9);
    run_slot(0, 5, 5, 3, 4);
    sb_on = 1'b0;
    hs_addr = -1;
    n_sc = 11'd100;
    n_rb = 7'd50;
    sym_start = 4'd0;
    sym_end = 4'd1;
    dmrs_sym = 4'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while (hs_addr != 500 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("reach500", hs_addr, 500);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {ifft_valid, ifft_last, slot_done, busy, data_ready, dmrs_ready}, 6'd0);
    chk("mid_rst_addr", ifft_addr, 11'd0);
    chk("mid_rst_iq", {ifft_i, ifft_q}, 36'd0);
    d0 = data_n;
    done_seen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_use", data_n, d0);
    chk("rst_no_done", done_seen, 1'b0);
    chk("rst_idle", busy, 1'b0);
    run_slot(100, 2, 0, 1, 5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
